// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_pkg                                                         |
// | Purpose  : Shared APB bus widths, completer FSM state encoding and the     |
// |            default address window / ID constants for the register file.   |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [APB_ADDR_W-1:0] DEF_BASE_ADDR = 32'h0000_A000;
  localparam logic [APB_DATA_W-1:0] DEF_ID_VALUE  = 32'h1600_0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } apb_slv_state_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_slave_regfile_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_slave_regfile_if                                            |
// | Purpose  : APB bus bundle shared by requester and completer.               |
// | Ports    : psel, penable, pwrite, paddr, pwdata  (requester -> completer)  |
// |            prdata, pready, pslverr              (completer -> requester)  |
// |            modports: master, slave                                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface apb_slave_regfile_if;
  import apb_pkg::*;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface : apb_slave_regfile_if
`default_nettype wire

// File: rtl/apb_slave_regbank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_slave_regbank                                               |
// | Purpose  : Register array behind the APB completer. Index 0 returns the    |
// |            fixed ID, index 1 the 16-bit committed-write counter, the rest  |
// |            are plain read/write registers.                                |
// | Ports    : pclk, preset_n        clock, synchronous active-low reset       |
// |            we, wr_index, wr_data write port (commit at the clock edge)     |
// |            rd_index, rd_data     combinational read port                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS = 8,
  parameter logic [APB_DATA_W-1:0] ID_VALUE = DEF_ID_VALUE
) (
  input  logic                        pclk,
  input  logic                        preset_n,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] wr_index,
  input  logic [APB_DATA_W-1:0]       wr_data,
  input  logic [$clog2(NUM_REGS)-1:0] rd_index,
  output logic [APB_DATA_W-1:0]       rd_data
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // Entries 0 and 1 are never written; their read values come from ID_VALUE
  // and the counter instead.
  logic [APB_DATA_W-1:0] r_regs [NUM_REGS];
  logic [15:0]           r_wr_cnt;
  logic                  w_rw_target;

  // Writes to the ID or counter slots are dropped without an error.
  assign w_rw_target = (32'(wr_index) >= 32'd2);

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_wr_cnt <= '0;
      for (int i = 2; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (we && w_rw_target) begin
      r_regs[wr_index] <= wr_data;
      r_wr_cnt         <= r_wr_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_index == '0) begin
      rd_data = ID_VALUE;
    end else if (rd_index == IDX_W'(1)) begin
      rd_data = {16'h0000, r_wr_cnt};
    end else begin
      rd_data = r_regs[rd_index];
    end
  end

endmodule : apb_slave_regbank
`default_nettype wire

// File: rtl/apb_slave_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : apb_slave_regfile                                               |
// | Purpose  : APB completer: decodes a fixed window of NUM_REGS 32-bit        |
// |            registers, inserts WAIT_CYCLES wait states and flags unaligned  |
// |            or out-of-window accesses with pslverr.                         |
// | Ports    : pclk      APB clock                                             |
// |            preset_n  synchronous active-low reset                          |
// |            apb       slave modport (psel/penable/pwrite/paddr/pwdata in,   |
// |                      prdata/pready/pslverr out, all outputs registered)    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = DEF_ID_VALUE
) (
  input  logic               pclk,
  input  logic               preset_n,
  apb_slave_regfile_if.slave apb
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [APB_ADDR_W-1:0] WINDOW_BYTES = APB_ADDR_W'(NUM_REGS * 4);

  apb_slv_state_t        r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_index;
  logic                  r_err;
  logic                  r_write;
  logic [APB_DATA_W-1:0] r_wdata;
  logic [APB_DATA_W-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic [APB_ADDR_W-1:0] w_offset;
  logic                  w_err;
  logic [IDX_W-1:0]      w_index;
  logic [IDX_W-1:0]      w_rd_index;
  logic [APB_DATA_W-1:0] w_rd_data;
  logic                  w_we;

  // Addresses below BASE_ADDR wrap to a huge offset and fall out of range.
  assign w_offset = apb.paddr - BASE_ADDR;
  assign w_err    = (apb.paddr[1:0] != 2'b00) || (w_offset >= WINDOW_BYTES);
  assign w_index  = w_offset[IDX_W+1:2];

  // With zero wait states READY is entered straight from the setup edge, so
  // the read port must see the live decode rather than the latched one.
  assign w_rd_index = (r_state == ST_IDLE) ? w_index : r_index;

  assign w_we = (r_state == ST_READY) && apb.psel && apb.penable &&
                r_write && !r_err;

  apb_slave_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regbank (
    .pclk     (pclk),
    .preset_n (preset_n),
    .we       (w_we),
    .wr_index (r_index),
    .wr_data  (r_wdata),
    .rd_index (w_rd_index),
    .rd_data  (w_rd_data)
  );

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_index   <= '0;
      r_err     <= 1'b0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_prdata  <= '0;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          // A lone penable without a preceding setup is ignored here.
          if (apb.psel && !apb.penable) begin
            r_index <= w_index;
            r_err   <= w_err;
            r_write <= apb.pwrite;
            r_wdata <= apb.pwdata;
            r_cnt   <= CNT_LOAD;
            if (WAIT_CYCLES == 0) begin
              r_state   <= ST_READY;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_err ? '0 : w_rd_data;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (!apb.psel) begin
            r_state <= ST_IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (apb.penable) begin
            r_state   <= ST_READY;
            r_pready  <= 1'b1;
            r_pslverr <= r_err;
            r_prdata  <= r_err ? '0 : w_rd_data;
          end
        end

        ST_READY: begin
          // Completion (psel & penable) or abort (psel low) both end here;
          // the write itself is committed by the bank on this same edge.
          if (!apb.psel || apb.penable) begin
            r_state   <= ST_IDLE;
            r_prdata  <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_prdata  <= '0;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
      endcase
    end
  end

  assign apb.prdata  = r_prdata;
  assign apb.pready  = r_pready;
  assign apb.pslverr = r_pslverr;

endmodule : apb_slave_regfile
`default_nettype wire

// File: tb/tb_apb_slave_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_apb_slave_regfile                                            |
// | Purpose  : Scoreboard bench for three apb_slave_regfile builds             |
// |            (WAIT_CYCLES = 0, 1, 3) sharing one requester driver.           |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_apb_slave_regfile;

  localparam logic [31:0] ID_VAL = 32'h1600_0001;
  localparam logic [31:0] BASE   = 32'h0000_A000;
  localparam int          MAX_CYC = 20;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic pclk;
  logic preset_n;

  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_paddr;
  logic [31:0] m_pwdata;
  int          sel;

  logic        s_pready;
  logic        s_pslverr;
  logic [31:0] s_prdata;

  int n_checks;
  int n_fail;

  exp_t        sb [$];
  logic [31:0] mdl_regs [3][8];
  logic [15:0] mdl_cnt  [3];
  int          wait_of  [3];

  apb_slave_regfile_if bus0 ();
  apb_slave_regfile_if bus1 ();
  apb_slave_regfile_if bus2 ();

  apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut0 (
    .pclk(pclk), .preset_n(preset_n), .apb(bus0.slave));
  apb_slave_regfile #(.WAIT_CYCLES(1)) u_dut1 (
    .pclk(pclk), .preset_n(preset_n), .apb(bus1.slave));
  apb_slave_regfile #(.WAIT_CYCLES(3)) u_dut2 (
    .pclk(pclk), .preset_n(preset_n), .apb(bus2.slave));

  // One requester, routed to whichever completer is selected.
  assign bus0.psel    = m_psel && (sel == 0);
  assign bus1.psel    = m_psel && (sel == 1);
  assign bus2.psel    = m_psel && (sel == 2);
  assign bus0.penable = m_penable;
  assign bus1.penable = m_penable;
  assign bus2.penable = m_penable;
  assign bus0.pwrite  = m_pwrite;
  assign bus1.pwrite  = m_pwrite;
  assign bus2.pwrite  = m_pwrite;
  assign bus0.paddr   = m_paddr;
  assign bus1.paddr   = m_paddr;
  assign bus2.paddr   = m_paddr;
  assign bus0.pwdata  = m_pwdata;
  assign bus1.pwdata  = m_pwdata;
  assign bus2.pwdata  = m_pwdata;

  always_comb begin
    s_pready  = bus1.pready;
    s_pslverr = bus1.pslverr;
    s_prdata  = bus1.prdata;
    if (sel == 0) begin
      s_pready  = bus0.pready;
      s_pslverr = bus0.pslverr;
      s_prdata  = bus0.prdata;
    end else if (sel == 2) begin
      s_pready  = bus2.pready;
      s_pslverr = bus2.pslverr;
      s_prdata  = bus2.prdata;
    end
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int d = 0; d < 3; d++) begin
      mdl_cnt[d] = 16'h0000;
      for (int i = 0; i < 8; i++) mdl_regs[d][i] = 32'h0;
    end
  endtask

  // Predicts the response of completer d and advances the model.
  task automatic mdl_access(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, output exp_t e);
    logic [31:0] off;
    logic [2:0]  idx;
    off     = addr - BASE;
    idx     = off[4:2];
    e.err   = (addr[1:0] != 2'b00) || (off >= 32'd32);
    e.lat   = wait_of[d] + 1;
    if (e.err)          e.rdata = 32'h0;
    else if (idx == 0)  e.rdata = ID_VAL;
    else if (idx == 1)  e.rdata = {16'h0000, mdl_cnt[d]};
    else                e.rdata = mdl_regs[d][idx];
    if (wr && !e.err && idx >= 3'd2) begin
      mdl_regs[d][idx] = data;
      mdl_cnt[d]       = mdl_cnt[d] + 16'd1;
    end
  endtask

  task automatic bus_idle();
    @(negedge pclk);
    m_psel    = 1'b0;
    m_penable = 1'b0;
  endtask

  task automatic apb_xfer(input string tag, input int d, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    exp_t got;
    int   cyc;
    logic done;
    mdl_access(d, wr, addr, data, e);
    sb.push_back(e);
    @(negedge pclk);
    sel       = d;
    m_psel    = 1'b1;
    m_penable = 1'b0;
    m_pwrite  = wr;
    m_paddr   = addr;
    m_pwdata  = data;
    @(negedge pclk);
    m_penable = 1'b1;
    cyc  = 1;
    done = 1'b0;
    while (!done && cyc <= MAX_CYC) begin
      if (s_pready) done = 1'b1;
      else begin
        @(negedge pclk);
        cyc++;
      end
    end
    got = sb.pop_front();
    check_val({tag, "_lat"}, 32'(cyc), 32'(got.lat));
    if (done) begin
      check_val({tag, "_rdata"}, s_prdata, got.rdata);
      check_val({tag, "_err"}, {31'h0, s_pslverr}, {31'h0, got.err});
    end
  endtask

  initial begin
    int cyc;
    n_checks   = 0;
    n_fail     = 0;
    wait_of[0] = 0;
    wait_of[1] = 1;
    wait_of[2] = 3;
    sel        = 1;
    m_psel     = 1'b0;
    m_penable  = 1'b0;
    m_pwrite   = 1'b0;
    m_paddr    = 32'h0;
    m_pwdata   = 32'h0;
    preset_n   = 1'b0;
    mdl_reset();
    repeat (3) @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    for (int d = 0; d < 3; d++) begin
      sel = d;
      #1;
      check_val("rst_pready", {31'h0, s_pready}, 32'h0);
      check_val("rst_pslverr", {31'h0, s_pslverr}, 32'h0);
      check_val("rst_prdata", s_prdata, 32'h0);
    end

    // Basic reads/writes on the single-wait build.
    apb_xfer("id_rd", 1, 1'b0, 32'h0000_A000, 32'h0);
    bus_idle();
    apb_xfer("wr_a008", 1, 1'b1, 32'h0000_A008, 32'hDEAD_BEEF);
    apb_xfer("rd_a008", 1, 1'b0, 32'h0000_A008, 32'h0);
    apb_xfer("rd_cnt1", 1, 1'b0, 32'h0000_A004, 32'h0);
    apb_xfer("wr_oor", 1, 1'b1, 32'h0000_A020, 32'h1111_1111);
    apb_xfer("wr_unal", 1, 1'b1, 32'h0000_A00A, 32'h2222_2222);
    apb_xfer("wr_below", 1, 1'b1, 32'h0000_9FFC, 32'h3333_3333);
    apb_xfer("rd_oor", 1, 1'b0, 32'h0000_A024, 32'h0);
    apb_xfer("rd_cnt_err", 1, 1'b0, 32'h0000_A004, 32'h0);
    apb_xfer("rd_a008_b", 1, 1'b0, 32'h0000_A008, 32'h0);
    apb_xfer("wr_id", 1, 1'b1, 32'h0000_A000, 32'h0000_1234);
    apb_xfer("wr_cnt", 1, 1'b1, 32'h0000_A004, 32'h0000_5678);
    apb_xfer("rd_id_b", 1, 1'b0, 32'h0000_A000, 32'h0);
    apb_xfer("rd_cnt_ro", 1, 1'b0, 32'h0000_A004, 32'h0);
    bus_idle();

    // Drop psel while the completer is still waiting: nothing may be written.
    @(negedge pclk);
    sel       = 1;
    m_psel    = 1'b1;
    m_penable = 1'b0;
    m_pwrite  = 1'b1;
    m_paddr   = 32'h0000_A00C;
    m_pwdata  = 32'h5555_5555;
    @(negedge pclk);
    check_val("abort_wait_pready", {31'h0, s_pready}, 32'h0);
    m_psel    = 1'b0;
    m_penable = 1'b0;
    @(negedge pclk);
    check_val("abort_idle_pready", {31'h0, s_pready}, 32'h0);
    apb_xfer("abort_rd", 1, 1'b0, 32'h0000_A00C, 32'h0);
    apb_xfer("abort_cnt", 1, 1'b0, 32'h0000_A004, 32'h0);
    bus_idle();

    // Counter wrap: preload 16'hFFFF, one write takes it to zero.
    force u_dut1.u_regbank.r_wr_cnt = 16'hFFFF;
    @(negedge pclk);
    release u_dut1.u_regbank.r_wr_cnt;
    mdl_cnt[1] = 16'hFFFF;
    apb_xfer("cnt_ffff", 1, 1'b0, 32'h0000_A004, 32'h0);
    apb_xfer("wr_a01c", 1, 1'b1, 32'h0000_A01C, 32'h0000_0077);
    apb_xfer("cnt_wrap", 1, 1'b0, 32'h0000_A004, 32'h0);
    apb_xfer("rd_a01c", 1, 1'b0, 32'h0000_A01C, 32'h0);
    bus_idle();

    // Zero-wait and three-wait builds, back-to-back write/read pairs.
    for (int d = 0; d < 3; d += 2) begin
      apb_xfer("b2b_wr0", d, 1'b1, 32'h0000_A008, 32'hA5A5_0000 + 32'(d));
      apb_xfer("b2b_rd0", d, 1'b0, 32'h0000_A008, 32'h0);
      apb_xfer("b2b_wr1", d, 1'b1, 32'h0000_A014, 32'h0F0F_F0F0 ^ 32'(d));
      apb_xfer("b2b_rd1", d, 1'b0, 32'h0000_A014, 32'h0);
      apb_xfer("b2b_err", d, 1'b1, 32'h0000_A022, 32'hFFFF_FFFF);
      apb_xfer("b2b_cnt", d, 1'b0, 32'h0000_A004, 32'h0);
      apb_xfer("b2b_id", d, 1'b0, 32'h0000_A000, 32'h0);
      bus_idle();
    end

    // Reset while a write sits in READY: it must not land.
    @(negedge pclk);
    sel       = 1;
    m_psel    = 1'b1;
    m_penable = 1'b0;
    m_pwrite  = 1'b1;
    m_paddr   = 32'h0000_A010;
    m_pwdata  = 32'hCAFE_F00D;
    @(negedge pclk);
    m_penable = 1'b1;
    cyc = 1;
    while (!s_pready && cyc <= MAX_CYC) begin
      @(negedge pclk);
      cyc++;
    end
    check_val("rstw_lat", 32'(cyc), 32'd2);
    preset_n = 1'b0;
    @(negedge pclk);
    check_val("rstw_pready", {31'h0, s_pready}, 32'h0);
    check_val("rstw_pslverr", {31'h0, s_pslverr}, 32'h0);
    check_val("rstw_prdata", s_prdata, 32'h0);
    preset_n  = 1'b1;
    m_psel    = 1'b0;
    m_penable = 1'b0;
    mdl_reset();
    apb_xfer("rstw_rd_a010", 1, 1'b0, 32'h0000_A010, 32'h0);
    apb_xfer("rstw_rd_a008", 1, 1'b0, 32'h0000_A008, 32'h0);
    apb_xfer("rstw_rd_cnt", 1, 1'b0, 32'h0000_A004, 32'h0);
    apb_xfer("rstw_rd_d2", 2, 1'b0, 32'h0000_A014, 32'h0);
    bus_idle();
    repeat (2) @(negedge pclk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_apb_slave_regfile
`default_nettype wire
